// File: rtl/b1_scfifo_af.sv
// ---------------------------------------------------------------------------
// b1_scfifo_af -- single-clock FIFO with almost-full / almost-empty flags
//
// Stores up to DEPTH = 2**AWIDTH words of DWIDTH bits. It supports two read
// modes:
//   SHOWAHEAD = "OFF" : q_o is registered. It loads the head word on the
//                       edge that accepts a read.
//   SHOWAHEAD = "ON"  : q_o always shows the head word while the FIFO is not
//                       empty. rdreq_i acknowledges that word. q_o holds the
//                       last shown word while the FIFO is empty.
// Overflow and underflow attempts are ignored and reported as one-cycle
// pulses.
//
// Ports
//   clk_i           in   1        clock, rising edge
//   arstn_i         in   1        asynchronous reset, active low
//   sclr_i          in   1        synchronous clear, active high
//   wrreq_i         in   1        write request
//   data_i          in   DWIDTH   write data
//   rdreq_i         in   1        read request / look-ahead acknowledge
//   q_o             out  DWIDTH   read data
//   empty_o         out  1        no words stored
//   full_o          out  1        DEPTH words stored
//   almost_empty_o  out  1        usedw_o <  ALMOST_EMPTY_VALUE
//   almost_full_o   out  1        usedw_o >= ALMOST_FULL_VALUE
//   usedw_o         out  AWIDTH+1 stored word count, 0..DEPTH
//   ovf_o           out  1        write attempted while full (pulse)
//   udf_o           out  1        read attempted while empty (pulse)
// ---------------------------------------------------------------------------
module b1_scfifo_af #(
    parameter int    DWIDTH             = 8,
    parameter int    AWIDTH             = 8,
    parameter string SHOWAHEAD          = "OFF",
    parameter int    ALMOST_FULL_VALUE  = 2**AWIDTH - 1,
    parameter int    ALMOST_EMPTY_VALUE = 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              sclr_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int              DEPTH     = 2**AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_THR    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_THR    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
    localparam bit              LOOKAHEAD = (SHOWAHEAD == "ON");

    // ---------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------
    generate
        if (SHOWAHEAD != "ON" && SHOWAHEAD != "OFF") begin : g_bad_showahead
            $error("b1_scfifo_af: SHOWAHEAD must be \"ON\" or \"OFF\"");
        end
        if (DWIDTH < 1 || AWIDTH < 1) begin : g_bad_width
            $error("b1_scfifo_af: DWIDTH and AWIDTH must be >= 1");
        end
        if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH) begin : g_bad_af
            $error("b1_scfifo_af: ALMOST_FULL_VALUE out of range 1..DEPTH");
        end
        if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH) begin : g_bad_ae
            $error("b1_scfifo_af: ALMOST_EMPTY_VALUE out of range 1..DEPTH");
        end
    endgenerate

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;

    logic              wr_acc;
    logic              rd_acc;
    logic [AWIDTH:0]   usedw_nxt;
    logic [AWIDTH:0]   after_read;
    logic [AWIDTH-1:0] rd_ptr_nxt;
    logic              fresh_head;
    logic [DWIDTH-1:0] q_nxt;

    // The status flags come only from the registered count. A request in the
    // current cycle cannot change them until the next edge.
    assign empty_o        = (usedw_o == '0);
    assign full_o         = (usedw_o == FULL_CNT);
    assign almost_full_o  = (usedw_o >= AF_THR);
    assign almost_empty_o = (usedw_o <  AE_THR);

    assign wr_acc = wrreq_i && !full_o;
    assign rd_acc = rdreq_i && !empty_o;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        usedw_nxt = usedw_o;
        unique case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw_o + CNT_ONE;
            2'b01:   usedw_nxt = usedw_o - CNT_ONE;
            default: usedw_nxt = usedw_o;
        endcase
    end

    assign rd_ptr_nxt = rd_acc ? (rd_ptr + PTR_ONE) : rd_ptr;

    // The new head is the word being written this cycle when the FIFO is
    // empty after this cycle's read. That word is not in memory yet, so it is
    // forwarded from data_i.
    assign after_read = usedw_o - {{AWIDTH{1'b0}}, rd_acc};
    assign fresh_head = wr_acc && (after_read == '0);

    always_comb begin
        q_nxt = q_o;
        if (LOOKAHEAD) begin
            // Present the head word after the edge. While the FIFO is empty,
            // keep the last word that was shown.
            if (usedw_nxt != '0) begin
                q_nxt = fresh_head ? data_i : mem[rd_ptr_nxt];
            end
        end else if (rd_acc) begin
            q_nxt = mem[rd_ptr];
        end
    end

    // ---------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_o <= '0;
            q_o     <= '0;
            ovf_o   <= 1'b0;
            udf_o   <= 1'b0;
        end else if (sclr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_o <= '0;
            q_o     <= '0;
            ovf_o   <= 1'b0;
            udf_o   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr  <= rd_ptr_nxt;
            usedw_o <= usedw_nxt;
            q_o     <= q_nxt;
            ovf_o   <= wrreq_i && full_o;
            udf_o   <= rdreq_i && empty_o;
        end
    end

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    // NOTE: the memory array has no reset, so it can map onto RAM. Stale
    // contents never reach q_o, because q_o loads only from valid entries or
    // from data_i.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !sclr_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_b1_scfifo_af.sv
// ---------------------------------------------------------------------------
// tb_b1_scfifo_af -- self-checking bench for b1_scfifo_af
//
// Two instances share one set of inputs: one in normal read mode and one in
// look-ahead mode (DEPTH 4, almost-full 3, almost-empty 1). A queue holds the
// words the bench expects to be stored. The queue is pushed on each accepted
// write and popped on each accepted read, and the popped word is the
// expected q_o of the normal-mode instance. Outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_b1_scfifo_af;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int DEP = 4;
    localparam int AFV = 3;
    localparam int AEV = 1;

    logic          clk_i = 1'b0;
    logic          arstn_i;
    logic          sclr_i;
    logic          wrreq_i;
    logic [DW-1:0] data_i;
    logic          rdreq_i;

    logic [DW-1:0] q_off,  q_on;
    logic          emp_off, emp_on, ful_off, ful_on;
    logic          ae_off, ae_on, af_off, af_on;
    logic [AW:0]   uw_off, uw_on;
    logic          ovf_off, ovf_on, udf_off, udf_on;

    always #5 clk_i = ~clk_i;

    b1_scfifo_af #(
        .DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("OFF"),
        .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
    ) dut_off (
        .clk_i(clk_i), .arstn_i(arstn_i), .sclr_i(sclr_i),
        .wrreq_i(wrreq_i), .data_i(data_i), .rdreq_i(rdreq_i),
        .q_o(q_off), .empty_o(emp_off), .full_o(ful_off),
        .almost_empty_o(ae_off), .almost_full_o(af_off),
        .usedw_o(uw_off), .ovf_o(ovf_off), .udf_o(udf_off)
    );

    b1_scfifo_af #(
        .DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("ON"),
        .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
    ) dut_on (
        .clk_i(clk_i), .arstn_i(arstn_i), .sclr_i(sclr_i),
        .wrreq_i(wrreq_i), .data_i(data_i), .rdreq_i(rdreq_i),
        .q_o(q_on), .empty_o(emp_on), .full_o(ful_on),
        .almost_empty_o(ae_on), .almost_full_o(af_on),
        .usedw_o(uw_on), .ovf_o(ovf_on), .udf_o(udf_on)
    );

    // Scoreboard and reference state
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_q_off;
    logic [DW-1:0] exp_q_on;
    logic          exp_ovf;
    logic          exp_udf;
    int            n_cmp;
    int            n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int cnt;
        cnt = sb.size();
        check({ctx, " off.usedw"}, 32'(uw_off), 32'(cnt));
        check({ctx, " on.usedw"},  32'(uw_on),  32'(cnt));
        check({ctx, " off.empty"}, 32'(emp_off), 32'(cnt == 0));
        check({ctx, " on.empty"},  32'(emp_on),  32'(cnt == 0));
        check({ctx, " off.full"},  32'(ful_off), 32'(cnt == DEP));
        check({ctx, " on.full"},   32'(ful_on),  32'(cnt == DEP));
        check({ctx, " off.aempty"}, 32'(ae_off), 32'(cnt < AEV));
        check({ctx, " on.aempty"},  32'(ae_on),  32'(cnt < AEV));
        check({ctx, " off.afull"},  32'(af_off), 32'(cnt >= AFV));
        check({ctx, " on.afull"},   32'(af_on),  32'(cnt >= AFV));
        check({ctx, " off.ovf"}, 32'(ovf_off), 32'(exp_ovf));
        check({ctx, " on.ovf"},  32'(ovf_on),  32'(exp_ovf));
        check({ctx, " off.udf"}, 32'(udf_off), 32'(exp_udf));
        check({ctx, " on.udf"},  32'(udf_on),  32'(exp_udf));
        check({ctx, " off.q"}, 32'(q_off), 32'(exp_q_off));
        check({ctx, " on.q"},  32'(q_on),  32'(exp_q_on));
    endtask

    task automatic model_reset();
        sb.delete();
        exp_q_off = '0;
        exp_q_on  = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // Apply one set of inputs for one clock cycle, update the model with the
    // values from before the edge, then compare after the edge.
    task automatic cycle(input string ctx, input logic wr, input logic [DW-1:0] d,
                         input logic rd, input logic clr);
        int  cnt;
        bit  wr_ok, rd_ok;
        wrreq_i = wr;
        data_i  = d;
        rdreq_i = rd;
        sclr_i  = clr;
        cnt   = sb.size();
        wr_ok = wr && (cnt < DEP);
        rd_ok = rd && (cnt > 0);
        if (clr) begin
            model_reset();
        end else begin
            exp_ovf = wr && (cnt == DEP);
            exp_udf = rd && (cnt == 0);
            if (rd_ok) exp_q_off = sb.pop_front();
            if (wr_ok) sb.push_back(d);
            if (sb.size() > 0) exp_q_on = sb[0];
        end
        @(posedge clk_i);
        #1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        sclr_i  = 1'b0;
        check_all(ctx);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        arstn_i = 1'b0;
        sclr_i  = 1'b0;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        data_i  = '0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        arstn_i = 1'b1;
        @(negedge clk_i);

        // Fill to full, then one more write, which overflows
        cycle("fill1", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("fill2", 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("fill3", 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("fill4", 1'b1, 8'h44, 1'b0, 1'b0);
        cycle("ovf",   1'b1, 8'h55, 1'b0, 1'b0);
        cycle("ovf_end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Drain, then one more read, which underflows
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("udf",     1'b0, 8'h00, 1'b1, 1'b0);
        cycle("udf_end", 1'b0, 8'h00, 1'b0, 1'b0);

        // Look-ahead: a word written into the empty FIFO appears without a read
        cycle("la_wr",   1'b1, 8'hA5, 1'b0, 1'b0);
        cycle("la_rd",   1'b0, 8'h00, 1'b1, 1'b0);
        cycle("la_hold", 1'b0, 8'h00, 1'b0, 1'b0);

        // Simultaneous read and write at full, mid-level and empty
        for (int i = 0; i < 4; i++) cycle("sim_fill", 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        cycle("sim_full", 1'b1, 8'hC0, 1'b1, 1'b0);
        cycle("sim_rd",   1'b0, 8'h00, 1'b1, 1'b0);
        cycle("sim_mid",  1'b1, 8'hC1, 1'b1, 1'b0);
        cycle("sim_rd",   1'b0, 8'h00, 1'b1, 1'b0);
        cycle("sim_rd",   1'b0, 8'h00, 1'b1, 1'b0);
        cycle("sim_empty", 1'b1, 8'hC2, 1'b1, 1'b0);

        // Synchronous clear overrides a write in the same cycle
        cycle("sclr_wr", 1'b1, 8'hEE, 1'b0, 1'b1);
        cycle("sclr_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Pointer wrap at a steady occupancy of 2
        cycle("wrap_pre", 1'b1, 8'h00, 1'b0, 1'b0);
        cycle("wrap_pre", 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 2; i < 10; i++) cycle("wrap", 1'b1, 8'(i), 1'b1, 1'b0);
        cycle("wrap_post", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("wrap_post", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with three words stored
        for (int i = 0; i < 3; i++) cycle("ar_fill", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        #3;
        arstn_i = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        #2;
        arstn_i = 1'b1;
        // The first write after reset must be the only stored word
        cycle("post_ar_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle("post_ar_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
